i2c_master: RTL
===============

Name: i2c_master

Overview:
- Byte-level I2C bus initiator. It drives SCL and SDA toward the existing LED (7'b1100100), FND (7'b1100101) and MEM (7'b1100110) I2C responder devices.
- A CPU-side peripheral wrapper issues START/WRITE/READ/STOP commands over a valid/ready handshake; this block generates bit timing, the ACK slots and repeated starts.
- Single master on the bus; no arbitration and no clock stretching.

Parameters:
- CLK_DIV, 250, clk cycles per quarter bit period (bit period = 4*CLK_DIV; 100 kHz at 100 MHz). Minimum value 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block can accept a command
- cmd  input  2  00 START, 01 WRITE, 10 READ, 11 STOP
- tx_data  input  8  byte for WRITE, captured on handshake
- ack_out  input  1  master ACK bit driven after READ (0 = ACK, 1 = NACK), captured on handshake
- rx_data  output  8  byte received by the last READ
- ack_in  output  1  ACK bit sampled from the slave after the last WRITE (0 = ACK)
- done  output  1  one-cycle pulse when a command completes
- err  output  1  set together with done when the command was illegal
- busy  output  1  bus owned (high from START until STOP completes)
- SCL  output  1  I2C clock, push-pull
- SDA  inout  1  I2C data; drives 0 or 'z only; a value other than 0 is read as 1

Behaviour:
- Reset: SCL=1, SDA='z, cmd_ready=1, rx_data=0, ack_in=1, done=0, err=0, busy=0, state IDLE, tick counter 0.
- Handshake:
  - A command is accepted on a cycle with cmd_valid && cmd_ready.
  - cmd_ready drops the next cycle and stays low until the cycle done pulses; cmd_ready is high again in that same cycle.
  - Command inputs are ignored while cmd_ready is low.
- Tick: the counter runs only while executing. It produces a tick every CLK_DIV cycles; each tick advances the quarter phase q0..q3.
- States: IDLE, HOLD (bus owned, SCL=0, SDA released), START, BIT, ACK, STOP.
- START from IDLE (4 quarters):
  - q0 SCL=1 SDA=z; q1 SCL=1 SDA=0; q2 SCL=0 SDA=0; q3 SCL=0 SDA=0.
  - Then HOLD, busy=1.
- START from HOLD (repeated start):
  - q0 SCL=0 SDA=z; q1 SCL=1 SDA=z; q2 SCL=1 SDA=0; q3 SCL=0 SDA=0.
- Data bit, MSB first, 8 bits then 1 ACK bit:
  - q0 SCL=0, SDA set up.
  - q1 and q2 SCL=1.
  - SDA sampled on the tick entering q2.
  - q3 SCL=0.
  - SDA changes only in q0.
- WRITE:
  - Drive tx_data bits.
  - Release SDA for the 9th bit; the sample goes to ack_in.
- READ:
  - Release SDA for 8 bits and shift samples into a shift register.
  - 9th bit drives ack_out.
  - rx_data updates on the cycle done pulses.
- STOP from HOLD:
  - q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2 SCL=1 SDA=z; q3 SCL=1 SDA=z.
  - Then IDLE, busy=0.
- Latency, accept to done:
  - START and STOP: 4*CLK_DIV+1 cycles.
  - WRITE and READ: 36*CLK_DIV+1 cycles.
- Illegal commands: WRITE, READ or STOP in IDLE; START is always legal.
  - Accepted anyway.
  - done=1 and err=1 the next cycle.
  - No bus activity.
  - rx_data and ack_in unchanged.
- err is cleared on the next accepted command.
- A NACK on WRITE does not abort. The block returns to HOLD; the issuer decides whether to send STOP.
- Reset mid-command: immediate return to reset values. SCL goes high and SDA is released in the same edge, with no STOP sequence (bench must tolerate this).

Decomposition:
- Package i2c_pkg:
  - i2c_cmd_e enum (START, WRITE, READ, STOP)
  - i2c_mst_state_e enum
  - localparams for the 7-bit device addresses LED, FND and MEM
- Sub-module i2c_tick_gen:
  - Parameter CLK_DIV; inputs clk, reset, en; output tick.
  - The counter clears whenever en=0.

Test Plan (CLK_DIV=4, SDA pullup, behavioural slave model acking address 7'b1100100):
- START, WRITE 8'hC8, WRITE 8'h5A, STOP -> ack_in=0 after each WRITE; slave observes 8'h5A; busy 1 then 0; SCL/SDA idle high at end; each WRITE done exactly 145 cycles after accept.
- START, WRITE 8'hFE (absent device) -> ack_in=1, err=0, block in HOLD; STOP -> busy=0.
- START, WRITE 8'hC9, READ ack_out=0, READ ack_out=1, STOP, with slave returning 8'hA5 then 8'h3C -> rx_data 8'hA5 then 8'h3C; master SDA low in 1st ACK slot, released in 2nd.
- START, WRITE 8'hCC, START (repeated), WRITE 8'hCD -> SDA falls while SCL high with no STOP in between; busy stays 1.
- WRITE in IDLE -> done and err one cycle after accept; SCL and SDA never change; following START clears err.
- Reset asserted at bit 4 of a WRITE -> next cycle SCL=1, SDA='z, busy=0, cmd_ready=1; a new START then completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and device addresses for the byte-level I2C initiator.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_STOP  = 2'b11
    } i2c_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } i2c_mst_state_e;

    localparam logic [6:0] ADDR_LED = 7'b1100100;
    localparam logic [6:0] ADDR_FND = 7'b1100101;
    localparam logic [6:0] ADDR_MEM = 7'b1100110;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator; one tick every CLK_DIV cycles while enabled.
module i2c_tick_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || !en || tick) cnt <= '0;
        else                      cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C initiator: START/WRITE/READ/STOP over a valid/ready command port.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       ack_out,
    output logic [7:0] rx_data,
    output logic       ack_in,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic       SCL,
    inout  wire        SDA
);

    i2c_mst_state_e state, state_n;
    i2c_cmd_e       cmd_e;

    logic [1:0] q;
    logic [2:0] bit_cnt;
    logic [7:0] sh;
    logic       is_read, rs, ack_bit;
    logic       tick, last_q, accept, legal, en;
    logic       scl_c, sda_low_c, scl_r, sda_low_r, sda_in;

    assign cmd_e     = i2c_cmd_e'(cmd);
    assign cmd_ready = (state == ST_IDLE) || (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign legal     = (state == ST_HOLD) || (cmd_e == CMD_START);
    assign en        = !cmd_ready;
    assign last_q    = tick && (q == 2'd3);

    // Bus pins come straight from flops so decode glitches never reach the wire.
    assign SCL    = scl_r;
    assign SDA    = sda_low_r ? 1'b0 : 1'bz;
    assign sda_in = (SDA == 1'b0) ? 1'b0 : 1'b1;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        scl_c     = 1'b1;
        sda_low_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && cmd_e == CMD_START) state_n = ST_START;
            end
            ST_HOLD: begin
                scl_c = 1'b0;
                if (accept) begin
                    case (cmd_e)
                        CMD_START: state_n = ST_START;
                        CMD_STOP:  state_n = ST_STOP;
                        default:   state_n = ST_BIT;
                    endcase
                end
            end
            ST_START: begin
                // Repeated start first raises SCL with SDA released, then pulls SDA.
                if (rs) begin
                    scl_c     = (q == 2'd1) || (q == 2'd2);
                    sda_low_c = (q >= 2'd2);
                end else begin
                    scl_c     = (q <= 2'd1);
                    sda_low_c = (q != 2'd0);
                end
                if (last_q) state_n = ST_HOLD;
            end
            ST_BIT: begin
                scl_c     = (q == 2'd1) || (q == 2'd2);
                sda_low_c = !is_read && !sh[7];
                if (last_q && bit_cnt == 3'd7) state_n = ST_ACK;
            end
            ST_ACK: begin
                scl_c     = (q == 2'd1) || (q == 2'd2);
                sda_low_c = is_read && !ack_bit;
                if (last_q) state_n = ST_HOLD;
            end
            ST_STOP: begin
                scl_c     = (q != 2'd0);
                sda_low_c = (q <= 2'd1);
                if (last_q) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_r     <= 1'b1;
            sda_low_r <= 1'b0;
            q         <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            is_read   <= 1'b0;
            rs        <= 1'b0;
            ack_bit   <= 1'b1;
            rx_data   <= '0;
            ack_in    <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            scl_r     <= scl_c;
            sda_low_r <= sda_low_c;
            done      <= 1'b0;
            if (accept) begin
                err     <= !legal;
                done    <= !legal;
                q       <= '0;
                bit_cnt <= '0;
                is_read <= (cmd_e == CMD_READ);
                rs      <= (state == ST_HOLD);
                ack_bit <= ack_out;
                if (legal && cmd_e == CMD_WRITE) sh <= tx_data;
            end else if (tick) begin
                q <= q + 1'b1;
                case (state)
                    ST_BIT: begin
                        if (q == 2'd1 && is_read) sh <= {sh[6:0], sda_in};
                        if (q == 2'd3) begin
                            if (!is_read) sh <= {sh[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_ACK: begin
                        if (q == 2'd1 && !is_read) ack_in <= sda_in;
                        if (q == 2'd3) begin
                            done <= 1'b1;
                            if (is_read) rx_data <= sh;
                        end
                    end
                    ST_START, ST_STOP: begin
                        if (q == 2'd3) done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
